// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - single-access SRAM phase sequencer with valid/ready request and response channels
module sram_access_ctrl #(
   parameter int WORD_SIZE    = 4,
   parameter int NUM_WORDS    = 16,
   parameter int NUM_ROWS     = 16,
   parameter int PRE_CYCLES   = 1,
   parameter int SENSE_CYCLES = 2,
   parameter int WRITE_CYCLES = 1,
   parameter int WB           = $clog2(NUM_WORDS),
   parameter int RB           = $clog2(NUM_ROWS),
   parameter int AW           = RB + WB
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [AW-1:0]        req_addr,
   input  logic [WORD_SIZE-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WORD_SIZE-1:0] rsp_rdata,
   output logic                 precharge_en,
   output logic [NUM_ROWS-1:0]  wl_en,
   output logic [NUM_WORDS-1:0] col_select,
   output logic                 sense_en,
   output logic                 write_en,
   output logic [WORD_SIZE-1:0] write_data,
   input  logic [WORD_SIZE-1:0] mux_data
);

   // Longest phase sets the counter range; counter counts down from length-1.
   localparam int PW_MAX = (PRE_CYCLES > SENSE_CYCLES) ? PRE_CYCLES : SENSE_CYCLES;
   localparam int CMAX   = (PW_MAX > WRITE_CYCLES) ? PW_MAX : WRITE_CYCLES;
   localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      READ  = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [AW-1:0] addr_q;
   logic          we_q;

   // Row and word fields of the latched address, used when opening the wordline.
   logic [RB-1:0] row_idx;
   logic [WB-1:0] word_idx;
   assign row_idx  = addr_q[AW-1:WB];
   assign word_idx = addr_q[WB-1:0];

   // Phase sequencer; every output is a register updated on the transition into the state that owns it.
   // write_data doubles as the latched wdata register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         precharge_en <= 1'b0;
         wl_en        <= '0;
         col_select   <= '0;
         sense_en     <= 1'b0;
         write_en     <= 1'b0;
         write_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  addr_q       <= req_addr;
                  we_q         <= req_we;
                  write_data   <= req_wdata;
                  cnt          <= CW'(PRE_CYCLES - 1);
                  req_ready    <= 1'b0;
                  precharge_en <= 1'b1;
                  state        <= PRE;
               end
            end
            PRE: begin
               if (cnt == '0) begin
                  // Bitlines are released the same edge the wordline opens, so the two never overlap.
                  precharge_en <= 1'b0;
                  wl_en        <= NUM_ROWS'(1) << row_idx;
                  col_select   <= NUM_WORDS'(1) << word_idx;
                  if (we_q) begin
                     write_en <= 1'b1;
                     cnt      <= CW'(WRITE_CYCLES - 1);
                     state    <= WRITE;
                  end else begin
                     sense_en <= 1'b1;
                     cnt      <= CW'(SENSE_CYCLES - 1);
                     state    <= READ;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            READ: begin
               if (cnt == '0) begin
                  rsp_rdata  <= mux_data;
                  rsp_valid  <= 1'b1;
                  sense_en   <= 1'b0;
                  wl_en      <= '0;
                  col_select <= '0;
                  state      <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WRITE: begin
               if (cnt == '0) begin
                  write_en   <= 1'b0;
                  wl_en      <= '0;
                  col_select <= '0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state        <= IDLE;
               req_ready    <= 1'b1;
               rsp_valid    <= 1'b0;
               precharge_en <= 1'b0;
               wl_en        <= '0;
               col_select   <= '0;
               sense_en     <= 1'b0;
               write_en     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - directed self-checking bench for sram_access_ctrl
module tb_sram_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [7:0]  req_addr = '0;
   logic [3:0]  req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [3:0]  rsp_rdata;
   logic        precharge_en;
   logic [15:0] wl_en;
   logic [15:0] col_select;
   logic        sense_en;
   logic        write_en;
   logic [3:0]  write_data;
   logic [3:0]  mux_data;

   logic [3:0]  mux_drive = '0;
   logic        use_model = 1'b0;
   logic [3:0]  mem [256];
   logic [7:0]  sel_idx;

   int checks = 0;
   int failures = 0;

   sram_access_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .precharge_en (precharge_en),
      .wl_en        (wl_en),
      .col_select   (col_select),
      .sense_en     (sense_en),
      .write_en     (write_en),
      .write_data   (write_data),
      .mux_data     (mux_data)
   );

   always #5 clk = ~clk;

   // Array model: encode the one-hot selects back to an address and echo stored data.
   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (wl_en[i])      sel_idx[7:4] = 4'(i);
         if (col_select[i]) sel_idx[3:0] = 4'(i);
      end
      mux_data = use_model ? mem[sel_idx] : mux_drive;
   end

   always @(posedge clk) begin
      if (write_en) mem[sel_idx] <= write_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 2 ns after the edge; phase isolation checked every cycle.
   task automatic tick();
      @(posedge clk);
      #2;
      chk("iso_pre_wl", 32'(precharge_en & (|wl_en)), 32'd0);
      chk("iso_sense_write", 32'(sense_en & write_en), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_precharge"}, 32'(precharge_en), 32'd0);
      chk({tag, "_wl_en"}, 32'(wl_en), 32'd0);
      chk({tag, "_col_select"}, 32'(col_select), 32'd0);
      chk({tag, "_sense_en"}, 32'(sense_en), 32'd0);
      chk({tag, "_write_en"}, 32'(write_en), 32'd0);
      chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
   endtask

   // Present a request in an IDLE cycle, take the accept edge, then withdraw it.
   task automatic accept(input logic we, input logic [7:0] addr, input logic [3:0] wdata);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;

      // Reset
      #1 rst_n = 1'b0;
      tick();
      tick();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Read 0x5A with mux output 4'hC, rsp_ready held high
      mux_drive = 4'hC;
      rsp_ready = 1'b1;
      accept(1'b0, 8'h5A, 4'h0);
      chk("rd_pre", 32'(precharge_en), 32'd1);
      chk("rd_pre_ready", 32'(req_ready), 32'd0);
      chk("rd_pre_wl", 32'(wl_en), 32'd0);
      tick();
      chk("rd_c1_pre", 32'(precharge_en), 32'd0);
      chk("rd_c1_wl", 32'(wl_en), 32'h0020);
      chk("rd_c1_col", 32'(col_select), 32'h0400);
      chk("rd_c1_sense", 32'(sense_en), 32'd1);
      tick();
      chk("rd_c2_wl", 32'(wl_en), 32'h0020);
      chk("rd_c2_sense", 32'(sense_en), 32'd1);
      chk("rd_c2_rsp", 32'(rsp_valid), 32'd0);
      tick();
      chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rd_rsp_rdata", 32'(rsp_rdata), 32'hC);
      chk("rd_rsp_sense", 32'(sense_en), 32'd0);
      chk("rd_rsp_wl", 32'(wl_en), 32'd0);
      tick();
      chk("rd_done_ready", 32'(req_ready), 32'd1);
      chk("rd_done_rsp", 32'(rsp_valid), 32'd0);

      // Write 4'h9 to 0xF0
      accept(1'b1, 8'hF0, 4'h9);
      chk("wr_pre", 32'(precharge_en), 32'd1);
      chk("wr_pre_rsp", 32'(rsp_valid), 32'd0);
      tick();
      chk("wr_wl", 32'(wl_en), 32'h8000);
      chk("wr_col", 32'(col_select), 32'h0001);
      chk("wr_we", 32'(write_en), 32'd1);
      chk("wr_data", 32'(write_data), 32'h9);
      chk("wr_sense", 32'(sense_en), 32'd0);
      chk("wr_rsp", 32'(rsp_valid), 32'd0);
      tick();
      chk("wr_done_ready", 32'(req_ready), 32'd1);
      chk("wr_done_we", 32'(write_en), 32'd0);
      chk("wr_done_rsp", 32'(rsp_valid), 32'd0);

      // Backpressure: rsp_ready low for 5 cycles with req_valid toggling
      mux_drive = 4'h6;
      rsp_ready = 1'b0;
      accept(1'b0, 8'h33, 4'h0);
      tick();
      tick();
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", 32'(rsp_rdata), 32'h6);
      mux_drive = 4'hF;
      for (int i = 0; i < 5; i++) begin
         req_valid = ~req_valid;
         req_we    = 1'b1;
         req_addr  = 8'(8'h40 + i);
         tick();
         chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
         chk("bp_hold_rdata", 32'(rsp_rdata), 32'h6);
         chk("bp_hold_ready", 32'(req_ready), 32'd0);
         chk("bp_hold_pre", 32'(precharge_en), 32'd0);
      end
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 8'h01;
      tick();
      chk("bp_release_rsp", 32'(rsp_valid), 32'd0);
      chk("bp_release_ready", 32'(req_ready), 32'd1);
      chk("bp_release_pre", 32'(precharge_en), 32'd0);
      tick();
      req_valid = 1'b0;
      chk("bp_next_pre", 32'(precharge_en), 32'd1);
      tick();
      chk("bp_next_wl", 32'(wl_en), 32'h0001);
      chk("bp_next_col", 32'(col_select), 32'h0002);
      tick();
      tick();
      chk("bp_next_rsp", 32'(rsp_valid), 32'd1);
      chk("bp_next_rdata", 32'(rsp_rdata), 32'hF);
      tick();

      // Reset during READ cycle 1
      mux_drive = 4'hC;
      accept(1'b0, 8'h5A, 4'h0);
      tick();
      chk("mid_sense_before", 32'(sense_en), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_async_wl", 32'(wl_en), 32'd0);
      chk("mid_async_sense", 32'(sense_en), 32'd0);
      tick();
      chk_reset_outputs("mid_reset");
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
         chk("mid_idle_ready", 32'(req_ready), 32'd1);
      end
      mux_drive = 4'hA;
      accept(1'b0, 8'h5A, 4'h0);
      tick();
      tick();
      tick();
      chk("mid_rd_valid", 32'(rsp_valid), 32'd1);
      chk("mid_rd_rdata", 32'(rsp_rdata), 32'hA);
      tick();

      // Back-to-back write then read of 0x12 through the array model
      use_model = 1'b1;
      accept(1'b1, 8'h12, 4'h3);
      tick();
      chk("b2b_wr_wl", 32'(wl_en), 32'h0002);
      chk("b2b_wr_col", 32'(col_select), 32'h0004);
      tick();
      chk("b2b_wr_ready", 32'(req_ready), 32'd1);
      accept(1'b0, 8'h12, 4'h0);
      tick();
      tick();
      tick();
      chk("b2b_rd_valid", 32'(rsp_valid), 32'd1);
      chk("b2b_rd_rdata", 32'(rsp_rdata), 32'h3);
      tick();
      chk("b2b_end_ready", 32'(req_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
